// File: rtl/tx_token_scheduler.sv
// SpaceWire transmit token scheduler: picks Time-Code > FCT > N-Char > NULL for the
// serializer, tracks transmit credit and pending FCTs, and gates token classes by link mode.
module tx_token_scheduler #(
    parameter int CREDIT_MAX   = 56,
    parameter int FCT_PEND_MAX = 7
) (
    input  logic       clock_sys,
    input  logic       tx_resetn,
    input  logic [1:0] link_state,
    input  logic       tick_in,
    input  logic [7:0] time_in,
    input  logic       fct_req,
    input  logic       rx_got_fct,
    input  logic       fifo_empty,
    input  logic [8:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tok_valid,
    output logic [1:0] tok_type,
    output logic [8:0] tok_data,
    input  logic       tok_ready,
    output logic [5:0] credit,
    output logic       credit_error,
    output logic       tick_overrun,
    output logic       state_dbg
);

    // Handshake: a token is transferred on every cycle where tok_valid && tok_ready;
    // while tok_valid is high and tok_ready is low, tok_type/tok_data are held stable.
    typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

    localparam logic [1:0] TOK_NULL  = 2'd0;
    localparam logic [1:0] TOK_FCT   = 2'd1;
    localparam logic [1:0] TOK_NCHAR = 2'd2;
    localparam logic [1:0] TOK_TIME  = 2'd3;
    localparam logic [6:0] CREDIT_LIM = 7'(CREDIT_MAX);
    localparam logic [2:0] FCT_SAT    = 3'(FCT_PEND_MAX);

    state_t     state;
    logic       tc_pend;
    logic [7:0] tc_val;
    logic [2:0] fct_pend;

    logic       link_up;
    logic       link_run;
    logic       do_load;
    logic       sel_tc;
    logic       sel_fct;
    logic       sel_nchar;
    logic       load_tc;
    logic       load_fct;
    logic       load_nchar;
    logic [6:0] credit_dec;
    logic [6:0] credit_add;
    logic       credit_ovf;

    assign link_up  = (link_state != 2'd0);
    assign link_run = (link_state == 2'd3);

    // A new token is chosen when idle, or in the same cycle the current one is taken.
    assign do_load = tx_resetn && link_up &&
                     ((state == S_IDLE) || (tok_valid && tok_ready));

    assign sel_tc    = tc_pend && link_run;
    assign sel_fct   = (fct_pend != 3'd0) && link_state[1];
    assign sel_nchar = !fifo_empty && (credit != 6'd0) && link_run;

    assign load_tc    = do_load && sel_tc;
    assign load_fct   = do_load && !sel_tc && sel_fct;
    assign load_nchar = do_load && !sel_tc && !sel_fct && sel_nchar;

    // The FIFO is show-ahead, so the pop must coincide with the load to allow back-to-back N-Chars.
    assign fifo_rd = load_nchar;

    // Overflow is judged after the same-cycle N-Char decrement.
    assign credit_dec = {1'b0, credit} - {6'd0, load_nchar};
    assign credit_add = credit_dec + 7'd8;
    assign credit_ovf = rx_got_fct && (credit_add > CREDIT_LIM);

    assign state_dbg = state;

    always_ff @(posedge clock_sys or negedge tx_resetn) begin
        if (!tx_resetn) begin
            state        <= S_IDLE;
            tok_valid    <= 1'b0;
            tok_type     <= TOK_NULL;
            tok_data     <= 9'd0;
            credit       <= 6'd0;
            credit_error <= 1'b0;
            tick_overrun <= 1'b0;
            tc_pend      <= 1'b0;
            tc_val       <= 8'd0;
            fct_pend     <= 3'd0;
        end else begin
            credit_error <= 1'b0;
            tick_overrun <= 1'b0;
            if (!link_up) begin
                // Link reset: drop any offered token (a popped N-Char is lost) and all bookkeeping.
                state     <= S_IDLE;
                tok_valid <= 1'b0;
                tok_type  <= TOK_NULL;
                tok_data  <= 9'd0;
                credit    <= 6'd0;
                fct_pend  <= 3'd0;
                tc_pend   <= 1'b0;
            end else begin
                if (do_load) begin
                    state     <= S_OFFER;
                    tok_valid <= 1'b1;
                    if (load_tc) begin
                        tok_type <= TOK_TIME;
                        tok_data <= {1'b0, tc_val};
                    end else if (load_fct) begin
                        tok_type <= TOK_FCT;
                        tok_data <= 9'd0;
                    end else if (load_nchar) begin
                        tok_type <= TOK_NCHAR;
                        tok_data <= fifo_dout;
                    end else begin
                        tok_type <= TOK_NULL;
                        tok_data <= 9'd0;
                    end
                end

                // A tick coinciding with a Time-Code load re-arms pending with the new value.
                if (tick_in) begin
                    tc_val  <= time_in;
                    tc_pend <= 1'b1;
                    if (tc_pend && !load_tc) begin
                        tick_overrun <= 1'b1;
                    end
                end else if (load_tc) begin
                    tc_pend <= 1'b0;
                end

                if (fct_req && !load_fct) begin
                    if (fct_pend != FCT_SAT) begin
                        fct_pend <= fct_pend + 3'd1;
                    end
                end else if (!fct_req && load_fct) begin
                    fct_pend <= fct_pend - 3'd1;
                end

                if (rx_got_fct && !credit_ovf) begin
                    credit <= credit_add[5:0];
                end else begin
                    credit <= credit_dec[5:0];
                end
                credit_error <= credit_ovf;
            end
        end
    end

endmodule
